// File: rtl/gf2_div_pkg.sv
// Shared definitions for the GF(2)[x] divider: operand widths, FSM states
// and the degree priority encoder used by several field blocks.
package gf2_div_pkg;

  localparam int N  = 142;        // divisor width
  localparam int SW = 8;          // shift-amount width, holds 0..N-1
  localparam int CW = 10;         // phase cycle counter width, holds up to 3N
  localparam int DW = 2 * N - 1;  // dividend / quotient width
  localparam int RW = N - 1;      // remainder width

  typedef enum logic [2:0] {
    IDLE,
    NORM,
    RUN,
    ALIGN,
    DONE
  } state_t;

  // Index of the highest set coefficient; returns 0 for the zero polynomial,
  // so callers must treat a zero operand separately.
  function automatic logic [SW-1:0] poly_deg(input logic [N-1:0] p);
    logic [SW-1:0] deg;
    deg = '0;
    for (int i = 0; i < N; i++) begin
      if (p[i]) deg = SW'(i);
    end
    return deg;
  endfunction

endpackage

// File: rtl/gf2_div_datapath.sv
// Datapath of the bit-serial GF(2)[x] long divider: dividend shifter D,
// normalised divisor d, partial remainder r and quotient shifter Q.
module gf2_div_datapath
  import gf2_div_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          norm_shift,
  input  logic          run_step,
  input  logic          align_shift,
  input  logic [DW-1:0] dividend,
  input  logic [N-1:0]  divisor,
  output logic [DW-1:0] quot,
  output logic [RW-1:0] rem
);

  logic [DW-1:0] dvd_q;
  logic [N-1:0]  dvs_q;
  logic [N-1:0]  rem_q;
  logic [N-1:0]  trial;
  logic [N-1:0]  rem_next;

  // One long-division step: bring down the next dividend bit and subtract
  // (xor) the normalised divisor whenever the leading coefficient is set.
  always_comb begin
    trial    = {rem_q[N-2:0], dvd_q[DW-1]};
    rem_next = trial[N-1] ? (trial ^ dvs_q) : trial;
  end

  // Operand capture, normalisation shift, division step and final align.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_q <= '0;
      dvs_q <= '0;
      rem_q <= '0;
      quot  <= '0;
    end else if (load) begin
      dvd_q <= dividend;
      dvs_q <= divisor;
      rem_q <= '0;
      quot  <= '0;
    end else begin
      if (norm_shift) begin
        dvs_q <= {dvs_q[N-2:0], 1'b0};
      end
      if (run_step) begin
        dvd_q <= {dvd_q[DW-2:0], 1'b0};
        rem_q <= rem_next;
        quot  <= {quot[DW-2:0], trial[N-1]};
      end
      if (align_shift) begin
        rem_q <= {1'b0, rem_q[N-1:1]};
      end
    end
  end

  assign rem = rem_q[N-2:0];

endmodule

// File: rtl/gf2_poly_divider_283bit.sv
// Sequential GF(2)[x] long divider for a 283-bit dividend and 142-bit
// divisor. Holds the control FSM, phase counter and valid/ready handshakes.
module gf2_poly_divider_283bit
  import gf2_div_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [N-1:0]  divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [RW-1:0] remainder,
  output logic          div_by_zero
);

  state_t        state;
  state_t        next_state;
  logic [SW-1:0] shift_amt;
  logic [SW-1:0] shift_new;
  logic [CW-1:0] cycle_cnt;
  logic [CW-1:0] shift_last;
  logic [CW-1:0] run_last;
  logic          dbz_q;
  logic          accept;
  logic          divisor_zero;
  logic          norm_shift;
  logic          run_step;
  logic          align_shift;
  logic [DW-1:0] quot_int;
  logic [RW-1:0] rem_int;

  assign in_ready     = (state == IDLE);
  assign accept       = in_valid & in_ready;
  assign divisor_zero = (divisor == '0);
  assign shift_new    = SW'(N - 1) - poly_deg(divisor);
  assign shift_last   = CW'(shift_amt) - CW'(1);
  assign run_last     = CW'(DW) + CW'(shift_amt) - CW'(1);

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic and per-phase datapath strobes.
  always_comb begin
    next_state  = state;
    norm_shift  = 1'b0;
    run_step    = 1'b0;
    align_shift = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (divisor_zero)         next_state = DONE;
          else if (shift_new != '0) next_state = NORM;
          else                      next_state = RUN;
        end
      end
      NORM: begin
        norm_shift = 1'b1;
        if (cycle_cnt == shift_last) next_state = RUN;
      end
      RUN: begin
        run_step = 1'b1;
        if (cycle_cnt == run_last) begin
          next_state = (shift_amt != '0) ? ALIGN : DONE;
        end
      end
      ALIGN: begin
        align_shift = 1'b1;
        if (cycle_cnt == shift_last) next_state = DONE;
      end
      DONE: begin
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Phase cycle counter restarts from zero on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
    end else if (next_state != state) begin
      cycle_cnt <= '0;
    end else if (state == NORM || state == RUN || state == ALIGN) begin
      cycle_cnt <= cycle_cnt + CW'(1);
    end
  end

  // Normalisation amount and divide-by-zero flag captured at accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_amt <= '0;
      dbz_q     <= 1'b0;
    end else if (accept) begin
      shift_amt <= divisor_zero ? '0 : shift_new;
      dbz_q     <= divisor_zero;
    end else if (state == DONE && out_ready) begin
      dbz_q     <= 1'b0;
    end
  end

  gf2_div_datapath u_datapath (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (accept),
    .norm_shift  (norm_shift),
    .run_step    (run_step),
    .align_shift (align_shift),
    .dividend    (dividend),
    .divisor     (divisor),
    .quot        (quot_int),
    .rem         (rem_int)
  );

  assign out_valid   = (state == DONE);
  assign quotient    = out_valid ? quot_int : '0;
  assign remainder   = out_valid ? rem_int : '0;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_gf2_poly_divider_283bit.sv
// Directed self-checking bench for the 283-bit GF(2)[x] long divider.
module tb_gf2_poly_divider_283bit;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [282:0] dividend;
  logic [141:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [282:0] quotient;
  logic [140:0] remainder;
  logic         div_by_zero;

  int compares;
  int mismatches;

  logic [282:0] p282;
  logic [141:0] p141p1;
  logic [282:0] rnd_dvd;
  logic [141:0] op_a;
  logic [141:0] op_b;
  logic [141:0] op_r;
  logic [282:0] op_y;
  int           lat;

  gf2_poly_divider_283bit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Schoolbook carry-less product used as the reference multiplier.
  function automatic logic [282:0] clmul(input logic [141:0] a, input logic [141:0] b);
    logic [282:0] acc;
    acc = '0;
    for (int i = 0; i < 142; i++) begin
      if (a[i]) acc = acc ^ ({141'b0, b} << i);
    end
    return acc;
  endfunction

  function automatic logic [141:0] rand142();
    logic [159:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[141:0];
  endfunction

  function automatic logic [282:0] rand283();
    logic [287:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
         $urandom(), $urandom(), $urandom(), $urandom()};
    return t[282:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [282:0] obs, input logic [282:0] exp);
    compares++;
    assert (obs === exp) else begin
      mismatches++;
      $error("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one operand pair for a single accept edge.
  task automatic applyStimulus(input logic [282:0] dvd, input logic [141:0] dvs);
    dividend = dvd;
    divisor  = dvs;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Count edges after the accept edge until out_valid, bounded.
  task automatic waitDone(input int limit, output int cycles);
    cycles = 0;
    while (out_valid !== 1'b1 && cycles < limit) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic releaseResult();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic runCase(input string tag, input logic [282:0] dvd, input logic [141:0] dvs,
                         input logic [282:0] exp_q, input logic [140:0] exp_r, input int exp_lat);
    int l;
    applyStimulus(dvd, dvs);
    waitDone(2000, l);
    checkOutput({tag, "_latency"}, 283'(l), 283'(exp_lat));
    checkOutput({tag, "_quotient"}, quotient, exp_q);
    checkOutput({tag, "_remainder"}, {142'b0, remainder}, {142'b0, exp_r});
    checkOutput({tag, "_dbz"}, {282'b0, div_by_zero}, 283'd0);
    releaseResult();
    checkOutput({tag, "_idle"}, {281'b0, in_ready, out_valid}, 283'd2);
  endtask

  initial begin
    compares   = 0;
    mismatches = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    dividend   = '0;
    divisor    = '0;
    p282       = 283'b1 << 282;
    p141p1     = (142'b1 << 141) | 142'b1;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", {282'b0, in_ready}, 283'd1);
    checkOutput("rst_out_valid", {282'b0, out_valid}, 283'd0);
    checkOutput("rst_quotient", quotient, 283'd0);
    checkOutput("rst_remainder", {142'b0, remainder}, 283'd0);
    checkOutput("rst_dbz", {282'b0, div_by_zero}, 283'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] small divisor (x^2+1)/(x+1)");
    runCase("small", 283'h5, 142'h3, 283'h3, 141'h0, 703);

    $display("[TB] full-degree divisor x^282/(x^141+1)");
    runCase("fulldeg", p282, p141p1, {141'b0, p141p1}, 141'h1, 283);

    $display("[TB] divisor one");
    rnd_dvd = rand283();
    runCase("div_one", rnd_dvd, 142'h1, rnd_dvd, 141'h0, 706);

    $display("[TB] divide by zero");
    applyStimulus(rnd_dvd, 142'h0);
    checkOutput("dbz_out_valid", {282'b0, out_valid}, 283'd1);
    checkOutput("dbz_flag", {282'b0, div_by_zero}, 283'd1);
    checkOutput("dbz_quotient", quotient, 283'd0);
    checkOutput("dbz_remainder", {142'b0, remainder}, 283'd0);
    checkOutput("dbz_in_ready_busy", {282'b0, in_ready}, 283'd0);
    releaseResult();
    checkOutput("dbz_in_ready_after", {282'b0, in_ready}, 283'd1);
    checkOutput("dbz_flag_cleared", {282'b0, div_by_zero}, 283'd0);

    $display("[TB] backpressure in DONE");
    applyStimulus(p282, p141p1);
    waitDone(2000, lat);
    checkOutput("bp_latency", 283'(lat), 283'd283);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      dividend = 283'h5;
      divisor  = 142'h3;
      @(posedge clk);
      #1;
      checkOutput("bp_quotient", quotient, {141'b0, p141p1});
      checkOutput("bp_remainder", {142'b0, remainder}, 283'd1);
      checkOutput("bp_handshake", {281'b0, in_ready, out_valid}, 283'd1);
    end
    in_valid = 1'b0;
    releaseResult();
    checkOutput("bp_release", {281'b0, in_ready, out_valid}, 283'd2);

    $display("[TB] reset during RUN");
    applyStimulus(p282, p141p1);
    repeat (100) @(posedge clk);
    #1;
    checkOutput("mid_busy", {282'b0, in_ready}, 283'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_out_valid", {282'b0, out_valid}, 283'd0);
    checkOutput("mid_rst_quotient", quotient, 283'd0);
    checkOutput("mid_rst_remainder", {142'b0, remainder}, 283'd0);
    checkOutput("mid_rst_dbz", {282'b0, div_by_zero}, 283'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    runCase("post_rst", p282 | 283'h1, p141p1, {141'b0, p141p1}, 141'h0, 283);

    $display("[TB] random product-plus-residue cases");
    for (int k = 0; k < 30; k++) begin
      int da;
      da = int'($urandom_range(141, 120));
      op_a = rand142();
      for (int i = 0; i < 142; i++) if (i > da) op_a[i] = 1'b0;
      op_a[da] = 1'b1;
      op_b = rand142();
      op_r = rand142();
      for (int i = 0; i < 142; i++) if (i >= da) op_r[i] = 1'b0;
      op_y = clmul(op_a, op_b) ^ {141'b0, op_r};
      runCase($sformatf("rand%0d", k), op_y, op_a, {141'b0, op_b}, op_r[140:0],
              283 + 3 * (141 - da));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
    $finish;
  end

endmodule
